sync_fifo_flow: RTL

Parametrised successor to the basic synchronous FIFO in the systolic datapath. Generalised to any integer depth, with wrap-around pointers for non-power-of-two depths. Output is first-word-fall-through (FWFT). Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and accepts a write while full when a read is accepted in the same cycle. Used between systolic array stages where producer and consumer rates differ and back-pressure must be anticipated.

---
 rtl/sync_fifo_flow.sv | 101 ++++++++++
 1 files changed

// File: rtl/sync_fifo_flow.sv
// sync_fifo_flow: first-word-fall-through synchronous FIFO of any depth, with occupancy count and thresholds.
// Define SYNC_FIFO_FLOW_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_flow #(
    parameter int NBITS     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wen,
    input  logic [NBITS-1:0] d,
    input  logic             ren,
    output logic [NBITS-1:0] q,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count
`ifdef SYNC_FIFO_FLOW_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [NBITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             rd_fire;
    logic             wr_fire;

    assign empty        = (count == '0);
    assign full         = (count == CNT_MAX);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A pop frees the slot, so a full FIFO still accepts a write alongside ren.
    assign rd_fire = ren & ~empty;
    assign wr_fire = wen & (~full | ren);

    assign q = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_fire && !clear) begin
            mem[wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_fire && !rd_fire) begin
                count <= count + 1'b1;
            end else if (rd_fire && !wr_fire) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FLOW_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && full && !ren) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
